// File: rtl/edge_scan_ctrl_pkg.sv
// Shared types for the edge-filter frame sequencer: FSM states and tap indexing.
package edge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CALC,
        WR_REQ,
        DONE
    } state_t;

    localparam int TAPS      = 9;
    localparam int TAP_IDX_W = 4;

    // Row-major index of a 3x3 tap from its window-relative row/column (0..2).
    function automatic logic [TAP_IDX_W-1:0] tap_index(input logic [1:0] tr, input logic [1:0] tc);
        return TAP_IDX_W'(3 * tr + tc);
    endfunction

endpackage

// File: rtl/edge_scan_ctrl_coord_scanner.sv
// Two-level wrap counter: inner runs INNER_LO..INNER_HI, outer steps when inner wraps.
// last is combinational and flags the final (outer, inner) pair.
module coord_scanner #(
    parameter int CW       = 16,
    parameter int OUTER_LO = 0,
    parameter int OUTER_HI = 2,
    parameter int INNER_LO = 0,
    parameter int INNER_HI = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] outer,
    output logic [CW-1:0] inner,
    output logic          last
);

    localparam logic [CW-1:0] O_LO = CW'(OUTER_LO);
    localparam logic [CW-1:0] O_HI = CW'(OUTER_HI);
    localparam logic [CW-1:0] I_LO = CW'(INNER_LO);
    localparam logic [CW-1:0] I_HI = CW'(INNER_HI);

    assign last = (outer == O_HI) && (inner == I_HI);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            outer <= O_LO;
            inner <= I_LO;
        end else if (inc) begin
            if (inner == I_HI) begin
                inner <= I_LO;
                outer <= (outer == O_HI) ? O_LO : outer + CW'(1);
            end else begin
                inner <= inner + CW'(1);
            end
        end
    end

endmodule

// File: rtl/edge_scan_ctrl.sv
// Frame sequencer: per interior pixel, reads the 3x3 window over Avalon-MM, strobes taps
// to the datapath, waits for its result and writes it back; stalls on waitrequest.
module edge_scan_ctrl
    import edge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    IMG_W      = 64,
    parameter int                    IMG_H      = 64,
    parameter int                    CW         = 16,
    parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] DST_BASE   = 'h10000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] avm_address_o,
    output logic                  avm_read_o,
    output logic                  avm_write_o,
    output logic [DATA_WIDTH-1:0] avm_writedata_o,
    input  logic                  avm_waitrequest_i,
    input  logic [DATA_WIDTH-1:0] avm_readdata_i,
    input  logic                  avm_readdatavalid_i,
    output logic                  tap_valid_o,
    output logic [DATA_WIDTH-1:0] tap_data_o,
    output logic [TAP_IDX_W-1:0]  tap_idx_o,
    output logic                  tap_last_o,
    input  logic                  res_valid_i,
    input  logic [DATA_WIDTH-1:0] res_data_i,
    output logic [CW-1:0]         cur_row_o,
    output logic [CW-1:0]         cur_col_o
);

    state_t                state;
    logic [CW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  pix_last;
    logic [1:0]            tr;
    logic [1:0]            tc;
    logic                  tap_last;
    logic [DATA_WIDTH-1:0] res_q;

    logic rd_data;
    logic wr_accept;
    assign rd_data   = (state == RD_WAIT) && avm_readdatavalid_i;
    assign wr_accept = (state == WR_REQ) && !avm_waitrequest_i;

    coord_scanner #(
        .CW      (CW),
        .OUTER_LO(1),
        .OUTER_HI(IMG_H - 2),
        .INNER_LO(1),
        .INNER_HI(IMG_W - 2)
    ) u_pix_scan (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(state == DONE),
        .inc  (wr_accept && !pix_last),
        .outer(row),
        .inner(col),
        .last (pix_last)
    );

    // The tap counter parks on (2,2) through CALC/WR_REQ and restarts once the write lands.
    coord_scanner #(
        .CW      (2),
        .OUTER_LO(0),
        .OUTER_HI(2),
        .INNER_LO(0),
        .INNER_HI(2)
    ) u_tap_scan (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(wr_accept || (state == DONE)),
        .inc  (rd_data && !tap_last),
        .outer(tr),
        .inner(tc),
        .last (tap_last)
    );

    // Window origin is (row-1, col-1); row/col never drop below 1, so no underflow.
    logic [CW-1:0]         src_row;
    logic [CW-1:0]         src_col;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    assign src_row  = row + CW'(tr) - CW'(1);
    assign src_col  = col + CW'(tc) - CW'(1);
    assign src_addr = SRC_BASE + ADDR_WIDTH'(src_row) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(src_col);
    assign dst_addr = DST_BASE + ADDR_WIDTH'(row) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(col);

    assign avm_address_o   = avm_write_o ? dst_addr : (avm_read_o ? src_addr : '0);
    assign avm_writedata_o = res_q;
    assign cur_row_o       = row;
    assign cur_col_o       = col;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            avm_read_o  <= 1'b0;
            avm_write_o <= 1'b0;
            tap_valid_o <= 1'b0;
            tap_data_o  <= '0;
            tap_idx_o   <= '0;
            tap_last_o  <= 1'b0;
            res_q       <= '0;
        end else begin
            done_o      <= 1'b0;
            tap_valid_o <= 1'b0;
            tap_last_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= RD_REQ;
                        busy_o     <= 1'b1;
                        avm_read_o <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest_i) begin
                        state      <= RD_WAIT;
                        avm_read_o <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid_i) begin
                        tap_valid_o <= 1'b1;
                        tap_data_o  <= avm_readdata_i;
                        tap_idx_o   <= tap_index(tr, tc);
                        tap_last_o  <= tap_last;
                        if (tap_last) begin
                            state <= CALC;
                        end else begin
                            state      <= RD_REQ;
                            avm_read_o <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (res_valid_i) begin
                        res_q       <= res_data_i;
                        state       <= WR_REQ;
                        avm_write_o <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest_i) begin
                        avm_write_o <= 1'b0;
                        if (pix_last) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= RD_REQ;
                            avm_read_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Bench for edge_scan_ctrl on a 4x4 frame: Avalon slave, datapath stub and a frame-level reference model.
module tb_edge_scan_ctrl;

    localparam int          AW  = 32;
    localparam int          DW  = 8;
    localparam int          W   = 4;
    localparam int          H   = 4;
    localparam int          CW  = 16;
    localparam logic [31:0] SRC = 32'h100;
    localparam logic [31:0] DST = 32'h200;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done;
    logic [AW-1:0] address;
    logic          rd, wr;
    logic [DW-1:0] writedata;
    logic          waitreq;
    logic [DW-1:0] readdata;
    logic          rdv;
    logic          tap_valid;
    logic [DW-1:0] tap_data;
    logic [3:0]    tap_idx;
    logic          tap_last;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [CW-1:0] cur_row, cur_col;

    edge_scan_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .CW(CW),
        .SRC_BASE(SRC), .DST_BASE(DST)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .avm_address_o(address), .avm_read_o(rd), .avm_write_o(wr),
        .avm_writedata_o(writedata), .avm_waitrequest_i(waitreq),
        .avm_readdata_i(readdata), .avm_readdatavalid_i(rdv),
        .tap_valid_o(tap_valid), .tap_data_o(tap_data), .tap_idx_o(tap_idx),
        .tap_last_o(tap_last), .res_valid_i(res_valid), .res_data_i(res_data),
        .cur_row_o(cur_row), .cur_col_o(cur_col)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Environment knobs and shared state.
    logic [7:0]  mem [16];
    int          lat = 1;
    int          dp_min = 1, dp_max = 3;
    int          stall_len = 5;
    int          stall_rd_at = -1, stall_wr_at = -1;
    int          stall_left_rd, stall_left_wr;
    bit          echo_mode = 0, inject_rdv = 0, inject_res = 0;
    int          rd_count, wr_count, done_count, last_wr_cyc;
    bit          in_calc = 0;
    logic [31:0] rd_q[$], wr_a_q[$];
    logic [7:0]  wr_d_q[$];
    logic [31:0] exp_rd[$], exp_wr_a[$];
    logic [7:0]  exp_wr_d[$];

    function automatic logic [7:0] model_res(input logic [7:0] t[9], input bit echo);
        int s = 0;
        for (int k = 0; k < 9; k++) s += (k + 1) * int'(t[k]);
        return echo ? t[4] : (8'(s) ^ 8'h5A);
    endfunction

    // Avalon slave plus datapath stub, acting on the falling edge.
    int          rsp_cnt = 0, calc_cnt = 0, tap_seq = 0;
    bit          stale = 0, tap_pend = 0;
    logic [7:0]  rsp_data, tap_exp;
    logic [7:0]  taps[9];
    logic [31:0] hold_rd, hold_wa;
    logic [7:0]  hold_wd;
    initial begin
        logic       nwait, nrdv, nres;
        logic [7:0] ndata, nresd;
        waitreq = 0; rdv = 0; readdata = 0; res_valid = 0; res_data = 0;
        forever begin
            @(negedge clk);
            nwait = 0; nrdv = 0; nres = 0;
            ndata = 8'($urandom); nresd = 8'($urandom);
            if (rst && rsp_cnt > 0) stale = 1;
            if (calc_cnt > 0) begin
                calc_cnt--;
                if (calc_cnt == 0) begin
                    nres = 1; nresd = model_res(taps, echo_mode); in_calc = 0;
                end
            end
            if (tap_valid) begin
                if (!tap_pend) check("tap_unexpected", tap_valid, 0);
                else begin
                    check("tap_data", tap_data, tap_exp);
                    check("tap_idx", tap_idx, tap_seq);
                    check("tap_last", tap_last, tap_seq == 8);
                    taps[tap_seq] = tap_data;
                    if (tap_seq == 8) begin
                        tap_seq = 0; in_calc = 1;
                        calc_cnt = $urandom_range(dp_min, dp_max);
                        if (inject_rdv) nrdv = 1;
                    end else tap_seq++;
                end
            end else if (tap_pend) check("tap_missing", tap_valid, 1);
            tap_pend = 0;
            if (rst) begin tap_seq = 0; calc_cnt = 0; in_calc = 0; end
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    nrdv = 1; ndata = rsp_data;
                    if (!stale) begin
                        tap_pend = 1; tap_exp = rsp_data;
                        if (inject_res) nres = 1;
                    end
                    stale = 0;
                end
            end
            if (rd && wr) check("rd_wr_overlap", {rd, wr}, 2'b10);
            if (rd) begin
                if (rd_count == stall_rd_at && stall_left_rd > 0) begin
                    if (stall_left_rd == stall_len) hold_rd = address;
                    else check("rd_hold_addr", address, hold_rd);
                    stall_left_rd--; nwait = 1;
                end else begin
                    if (rd_count == stall_rd_at) check("rd_hold_addr", address, hold_rd);
                    rd_q.push_back(address); rd_count++; rsp_cnt = lat;
                    rsp_data = (address - SRC < 16) ? mem[address - SRC] : 8'hEE;
                end
            end else if (rd_count == stall_rd_at && stall_left_rd < stall_len)
                check("rd_hold_req", rd, 1);
            if (wr) begin
                if (wr_count == stall_wr_at && stall_left_wr > 0) begin
                    if (stall_left_wr == stall_len) begin hold_wa = address; hold_wd = writedata; end
                    else begin
                        check("wr_hold_addr", address, hold_wa);
                        check("wr_hold_data", writedata, hold_wd);
                    end
                    stall_left_wr--; nwait = 1;
                end else begin
                    if (wr_count == stall_wr_at) check("wr_hold_addr", address, hold_wa);
                    wr_a_q.push_back(address); wr_d_q.push_back(writedata);
                    wr_count++; last_wr_cyc = cyc;
                end
            end else if (wr_count == stall_wr_at && stall_left_wr < stall_len)
                check("wr_hold_req", wr, 1);
            if (done) begin
                done_count++;
                check("done_latency", cyc - last_wr_cyc, 1);
            end
            waitreq = nwait; rdv = nrdv; readdata = ndata; res_valid = nres; res_data = nresd;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: every interior pixel, its 3x3 window in row-major order, and its result.
    task automatic prep(input bit echo);
        rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
        exp_rd.delete(); exp_wr_a.delete(); exp_wr_d.delete();
        rd_count = 0; wr_count = 0; done_count = 0;
        stall_left_rd = stall_len; stall_left_wr = stall_len;
        echo_mode = echo;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                logic [7:0] t[9];
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int a = (r + dr) * W + (c + dc);
                        exp_rd.push_back(SRC + 32'(a));
                        t[(dr + 1) * 3 + dc + 1] = mem[a];
                    end
                end
                exp_wr_a.push_back(DST + 32'(r * W + c));
                exp_wr_d.push_back(model_res(t, echo));
            end
        end
    endtask

    task automatic launch(input string tag, input bit hold);
        start = 1;
        step();
        check({tag, "_first_read"}, rd, 1);
        check({tag, "_first_addr"}, address, SRC);
        check({tag, "_busy"}, busy, 1);
        if (!hold) start = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_count == 0 && n < 4000) begin step(); n++; end
        check({tag, "_done_once"}, done_count, 1);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_row_home"}, cur_row, 1);
        check({tag, "_col_home"}, cur_col, 1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_n_reads"}, rd_q.size(), exp_rd.size());
        check({tag, "_n_writes"}, wr_a_q.size(), exp_wr_a.size());
        for (int i = 0; i < exp_rd.size(); i++) check({tag, "_rd_addr"}, rd_q[i], exp_rd[i]);
        for (int i = 0; i < exp_wr_a.size(); i++) begin
            check({tag, "_wr_addr"}, wr_a_q[i], exp_wr_a[i]);
            check({tag, "_wr_data"}, wr_d_q[i], exp_wr_d[i]);
        end
    endtask

    initial begin
        logic [31:0] t1_rd[9];
        logic [31:0] t1_wr[4];
        int n;
        t1_rd = '{32'h100, 32'h101, 32'h102, 32'h104, 32'h105, 32'h106, 32'h108, 32'h109, 32'h10A};
        t1_wr = '{32'h205, 32'h206, 32'h209, 32'h20A};
        rst = 1; start = 0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", address, 0);
        check("rst_read", rd, 0);
        check("rst_write", wr, 0);
        check("rst_wdata", writedata, 0);
        check("rst_tap_valid", tap_valid, 0);
        check("rst_tap_data", tap_data, 0);
        check("rst_tap_idx", tap_idx, 0);
        check("rst_tap_last", tap_last, 0);
        check("rst_row", cur_row, 1);
        check("rst_col", cur_col, 1);
        rst = 0;
        step();

        // Plain frame, read latency 1.
        prep(0); launch("t1", 0); wait_done("t1"); compare("t1");
        for (int i = 0; i < 9; i++) check("t1_plan_rd", rd_q[i], t1_rd[i]);
        for (int i = 0; i < 4; i++) check("t1_plan_wr", wr_a_q[i], t1_wr[i]);

        // Waitrequest stalls on read tap 4 and on the first write.
        stall_rd_at = 4; stall_wr_at = 0;
        prep(0); launch("t2", 0); wait_done("t2"); compare("t2");
        check("t2_rd_stalled", stall_left_rd, 0);
        check("t2_wr_stalled", stall_left_wr, 0);
        stall_rd_at = -1; stall_wr_at = -1;

        // Stray res_valid in RD_WAIT and stray readdatavalid in CALC, latency 2.
        lat = 2; inject_rdv = 1; inject_res = 1;
        prep(0); launch("t3", 0); wait_done("t3"); compare("t3");
        inject_rdv = 0; inject_res = 0; lat = 1;

        // Reset while waiting on the datapath for pixel (1,2), then a clean rescan.
        dp_min = 30; dp_max = 30;
        prep(0); launch("t4", 0);
        n = 0;
        while (!(wr_count == 1 && in_calc) && n < 2000) begin step(); n++; end
        check("t4_calc_row", cur_row, 1);
        check("t4_calc_col", cur_col, 2);
        rst = 1;
        step();
        check("t4_rst_busy", busy, 0);
        check("t4_rst_read", rd, 0);
        check("t4_rst_write", wr, 0);
        check("t4_rst_row", cur_row, 1);
        check("t4_rst_col", cur_col, 1);
        rst = 0;
        dp_min = 1; dp_max = 3;
        step();
        prep(0); launch("t4b", 0); wait_done("t4b"); compare("t4b");

        // Reset with a read outstanding: the late readdatavalid must not produce a tap.
        lat = 4;
        prep(0); launch("t5", 0);
        n = 0;
        while (rd_count < 3 && n < 200) begin step(); n++; end
        rst = 1;
        step();
        rst = 0;
        repeat (8) step();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_read", rd, 0);
        lat = 2;
        prep(0); launch("t5b", 0); wait_done("t5b"); compare("t5b");

        // start held high: one frame, then the next frame right after IDLE.
        lat = 1;
        prep(0); launch("t6", 1); wait_done("t6"); compare("t6");
        prep(1);
        step();
        check("t6_restart_read", rd, 1);
        check("t6_restart_addr", address, SRC);
        start = 0;
        wait_done("t6b"); compare("t6b");
        repeat (6) step();
        check("t6_stays_idle", rd, 0);
        check("t6_no_extra_reads", rd_q.size(), exp_rd.size());

        // Datapath echoes the centre tap, longer read latency.
        lat = 3; dp_max = 6;
        prep(1); launch("t7", 0); wait_done("t7"); compare("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
